conv_accumulator: RTL and testbench

- Sequential accumulator directly downstream of the convolution adder datapath.
- Consumes a stream of sign-magnitude products, one per kernel tap, and sums KERNEL_SIZE of them into one convolution output pixel.
- Hands each result to the next stage over a valid/ready handshake.
- All data is sign-magnitude, 2*WIDTH bits: MSB is the sign, the low 2*WIDTH-1 bits are the magnitude.

---
 rtl/conv_accumulator.sv | 141 ++++++++++++++
 tb/tb_conv_accumulator.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_accumulator.sv
// Sign-magnitude window accumulator with a valid/ready result port.
// Optional CONV_ACC_RELU_EN clamps negative window sums to zero.
module conv_accumulator #(
  parameter int WIDTH       = 9,
  parameter int KERNEL_SIZE = 9,
  parameter int GUARD       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [2*WIDTH-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sat
);

  localparam int DW = 2 * WIDTH;
  localparam int MW = DW - 1 + GUARD;
  localparam int CW = $clog2(KERNEL_SIZE);

  typedef enum logic {ACCUM, OUTPUT} state_t;

  state_t          state, state_n;
  logic            acc_sign, acc_sign_n;
  logic [MW-1:0]   acc_mag, acc_mag_n;
  logic [CW-1:0]   count, count_n;
  logic [DW-1:0]   out_data_n;
  logic            out_valid_n, out_sat_n;

  logic [MW-1:0]   in_mag, sum_mag;
  logic            in_sign, sum_sign;
  logic [DW-2:0]   fmt_mag;
  logic            fmt_sign, fmt_sat;
  logic            take, last;

  assign in_ready = (state == ACCUM);
  assign take     = in_valid && in_ready;
  assign last     = (count == CW'(KERNEL_SIZE - 1));
  assign in_mag   = MW'(in_data[DW-2:0]);
  // -0 on the input is folded to +0 so sign compare stays meaningful
  assign in_sign  = in_data[DW-1] && (in_data[DW-2:0] != '0);

  always_comb begin
    sum_mag  = '0;
    sum_sign = 1'b0;
    if (acc_sign == in_sign) begin
      sum_mag  = acc_mag + in_mag;
      sum_sign = acc_sign;
    end else if (acc_mag >= in_mag) begin
      sum_mag  = acc_mag - in_mag;
      sum_sign = acc_sign;
    end else begin
      sum_mag  = in_mag - acc_mag;
      sum_sign = in_sign;
    end
    if (sum_mag == '0) sum_sign = 1'b0;
  end

  always_comb begin
    fmt_sat  = |sum_mag[MW-1:DW-1];
    fmt_mag  = fmt_sat ? '1 : sum_mag[DW-2:0];
    fmt_sign = sum_sign;
`ifdef CONV_ACC_RELU_EN
    if (sum_sign) begin
      fmt_sat  = 1'b0;
      fmt_mag  = '0;
      fmt_sign = 1'b0;
    end
`endif
  end

  always_comb begin
    state_n     = state;
    acc_sign_n  = acc_sign;
    acc_mag_n   = acc_mag;
    count_n     = count;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    out_sat_n   = out_sat;
    if (clr) begin
      state_n     = ACCUM;
      acc_sign_n  = 1'b0;
      acc_mag_n   = '0;
      count_n     = '0;
      out_data_n  = '0;
      out_valid_n = 1'b0;
      out_sat_n   = 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (take) begin
            acc_sign_n = sum_sign;
            acc_mag_n  = sum_mag;
            if (last) begin
              state_n     = OUTPUT;
              out_data_n  = {fmt_sign, fmt_mag};
              out_sat_n   = fmt_sat;
              out_valid_n = 1'b1;
            end else begin
              count_n = count + CW'(1);
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state_n     = ACCUM;
            acc_sign_n  = 1'b0;
            acc_mag_n   = '0;
            count_n     = '0;
            out_valid_n = 1'b0;
          end
        end
        default: state_n = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc_sign  <= 1'b0;
      acc_mag   <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      state     <= state_n;
      acc_sign  <= acc_sign_n;
      acc_mag   <= acc_mag_n;
      count     <= count_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      out_sat   <= out_sat_n;
    end
  end

endmodule

// File: tb/tb_conv_accumulator.sv
// Scoreboard bench for conv_accumulator: integer reference model,
// directed corner windows plus randomized windows and backpressure.
module tb_conv_accumulator;

  localparam int K    = 9;
  localparam int MAXM = (1 << 17) - 1;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready;
  logic        out_valid, out_ready, out_sat;
  logic [17:0] in_data, out_data;

  typedef struct packed {
    logic [17:0] data;
    logic        sat;
  } res_t;

  res_t        sb[$];
  logic [17:0] win[$];
  int          checks = 0;
  int          errors = 0;
  bit          rand_ready = 1'b0;
  bit          ready_force = 1'b1;

  always #5 clk = ~clk;

  conv_accumulator #(.WIDTH(9), .KERNEL_SIZE(K), .GUARD(4)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sat(out_sat)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model();
    longint s;
    longint m;
    longint mag;
    bit     neg;
    res_t   r;
    s = 0;
    foreach (win[i]) begin
      m = longint'(win[i][16:0]);
      s = win[i][17] ? s - m : s + m;
    end
    neg   = (s < 0);
    mag   = neg ? -s : s;
    r.sat = (mag > MAXM);
    if (r.sat) mag = MAXM;
    r.data = {neg && (mag != 0), mag[16:0]};
`ifdef CONV_ACC_RELU_EN
    if (neg) r = '0;
`endif
    return r;
  endfunction

  task automatic accept(input logic [17:0] d);
    win.push_back(d);
    if (win.size() == K) begin
      sb.push_back(model());
      win.delete();
    end
  endtask

  task automatic send(input logic [17:0] d, input int gap);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    accept(d);
    in_valid = 1'b0;
    in_data  = 18'($urandom);
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_n(input logic [17:0] d, input int n, input int gap);
    for (int i = 0; i < n; i++) send(d, gap);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic pulse_clr();
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 18'h00077;
    @(posedge clk); #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    win.delete();
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    win.delete();
  endtask

  function automatic logic [17:0] rand_beat();
    logic [17:0] d;
    d[17] = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0)
      d[16:0] = 17'($urandom_range(MAXM - 2000, MAXM));
    else
      d[16:0] = 17'($urandom_range(0, 300));
    return d;
  endfunction

  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {14'd0, out_data}, 32'd0);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("out_data", {14'd0, out_data}, {14'd0, e.data});
        chk("out_sat", 32'(out_sat), 32'(e.sat));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 18'h3FFFF;
    out_ready = 1'b1;
    #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_sat", 32'(out_sat), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end

    send_n(18'h0000A, K, 0);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    chk("basic_sum", {14'd0, out_data}, 32'h0005A);
    drain();

    send(18'h00005, 0); send(18'h20008, 0); send(18'h00002, 0);
    send_n(18'h00000, 6, 0);
    send(18'h00007, 0); send(18'h20007, 0);
    send_n(18'h00000, 7, 0);
    drain();

    send_n(18'h1FFFF, K, 0);
    send_n(18'h3FFFF, K, 0);
    drain();

    send(18'h20000, 1); send(18'h20003, 1);
    send_n(18'h0000A, K - 2, 1);
    drain();

    ready_force = 1'b0;
    @(posedge clk); #1;
    send_n(18'h00011, K, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 18'($urandom);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_data", {14'd0, out_data}, {14'd0, sb[0].data});
      @(posedge clk); #1;
    end
    in_valid    = 1'b0;
    ready_force = 1'b1;
    send_n(18'h00001, K, 0);
    drain();

    send_n(18'h00021, 4, 0);
    pulse_clr();
    send_n(18'h00003, K, 0);
    drain();

    ready_force = 1'b0;
    @(posedge clk); #1;
    send_n(18'h00006, K, 0);
    pulse_clr();
    void'(sb.pop_back());
    chk("clr_output_valid", 32'(out_valid), 32'd0);
    ready_force = 1'b1;
    @(posedge clk); #1;

    send_n(18'h00005, 6, 0);
    async_reset();
    send_n(18'h00002, K, 0);
    drain();

    ready_force = 1'b0;
    @(posedge clk); #1;
    send_n(18'h00009, K, 0);
    async_reset();
    void'(sb.pop_back());
    ready_force = 1'b1;
    @(posedge clk); #1;

    rand_ready = 1'b1;
    for (int w = 0; w < 30; w++) begin
      for (int b = 0; b < K; b++) send(rand_beat(), $urandom_range(0, 2));
    end
    drain();
    rand_ready = 1'b0;

`ifdef CONV_ACC_RELU_EN
    send_n(18'h20004, K, 0);
    send_n(18'h00004, K, 0);
    drain();
`endif

    chk("leftover_partial", 32'(win.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
